// File: rtl/ps2_pkg.sv
// Shared PS/2 types and helpers for the host transmit and receive paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_STOP_IDX  = 9;

    function automatic logic odd_parity(input logic [PS2_DATA_BITS-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes the raw PS/2 clock and data lines and flags their falling edges.
// Flops reset low so a line that is really low never produces a false idle or edge.
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_s_o,
    output logic data_s_o,
    output logic clk_fall_o,
    output logic data_fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   data_prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
            data_prev_q <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
            data_prev_q <= data_sync_q[SYNC_STAGES-1];
        end
    end

    assign clk_s_o     = clk_sync_q[SYNC_STAGES-1];
    assign data_s_o    = data_sync_q[SYNC_STAGES-1];
    assign clk_fall_o  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_fall_o = data_prev_q & ~data_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits, odd parity, stop, device ACK.
// Build option PS2_TX_RETRY_EN: a NACKed or timed-out frame is resent once before tx_err is reported.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 1500,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] INH_DRV  = CW'((INHIBIT_CYCLES >= 2) ? INHIBIT_CYCLES - 2 : 0);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    logic clk_s, data_s, clk_fall, data_fall_unused;

    ps2_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk_i  (ps2_clk_in),
        .ps2_data_i (ps2_data_in),
        .clk_s_o    (clk_s),
        .data_s_o   (data_s),
        .clk_fall_o (clk_fall),
        .data_fall_o(data_fall_unused)
    );

    ps2_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    byte_q, byte_d;
    logic          par_q, par_d, ack_q, ack_d;
    logic          clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic          done_q, done_d, err_q, err_d, busy_q, busy_d, ready_q, ready_d;
    logic          tx_bit, succ, fail;
`ifdef PS2_TX_RETRY_EN
    logic          retry_q, retry_d;
`endif

    assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        if (bit_cnt_q < 4'(PS2_DATA_BITS))       tx_bit = byte_q[bit_cnt_q[2:0]];
        else if (bit_cnt_q == 4'(PS2_DATA_BITS)) tx_bit = par_q;
        else                                     tx_bit = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        byte_d    = byte_q;
        par_d     = par_q;
        ack_d     = ack_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        succ      = 1'b0;
        fail      = 1'b0;
`ifdef PS2_TX_RETRY_EN
        retry_d   = retry_q;
`endif
        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid && ready_q) begin
                    byte_d   = tx_data;
                    par_d    = odd_parity(tx_data);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_d  = 1'b0;
`endif
                end
            end
            INHIBIT: begin
                cnt_d = cnt_inc;
                // Start bit goes onto the bus while the clock is still held low.
                if (cnt_q >= INH_DRV) data_oe_d = 1'b1;
                if (cnt_q == INH_LAST) begin
                    clk_oe_d  = 1'b0;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    data_oe_d = ~tx_bit;
                    if (bit_cnt_q == 4'(PS2_STOP_IDX)) state_d = ACK;
                    else                               bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (cnt_q == TO_LAST) fail = 1'b1;
                else                           cnt_d = cnt_inc;
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d   = '0;
                    ack_d   = ~data_s;
                    state_d = WAIT_IDLE;
                end else if (cnt_q == TO_LAST) fail = 1'b1;
                else                           cnt_d = cnt_inc;
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    if (ack_q) succ = 1'b1;
                    else       fail = 1'b1;
                end else if (clk_fall)         cnt_d = '0;
                else if (cnt_q == TO_LAST)     fail = 1'b1;
                else                           cnt_d = cnt_inc;
            end
            default: state_d = IDLE;
        endcase

        if (succ) begin
            done_d  = 1'b1;
            state_d = IDLE;
        end
        if (fail) begin
`ifdef PS2_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                cnt_d     = '0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                state_d   = INHIBIT;
            end else begin
                err_d     = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                state_d   = IDLE;
            end
`else
            err_d     = 1'b1;
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = IDLE;
`endif
        end

        busy_d  = (state_d != IDLE);
        ready_d = (state_d == IDLE) && clk_s && data_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            byte_q    <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            byte_q    <= byte_d;
            par_q     <= par_d;
            ack_q     <= ack_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef PS2_TX_RETRY_EN
            retry_q   <= retry_d;
`endif
        end
    end

    assign tx_ready    = ready_q;
    assign busy        = busy_q;
    assign tx_done     = done_q;
    assign tx_err      = err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter, the send direction for the PS/2 receiver. Sends command bytes such as LED set, reset (0xFF) and typematic to the keyboard or mouse.
- Runs on the system clock and oversamples the device-generated PS/2 clock.
- Drives the open-drain PS/2 clock and data lines through active-high pull-low enables.
- Frame: inhibit, request-to-send (start bit 0), 8 data bits LSB first, odd parity, stop bit 1, device ACK.

Parameters:
- INHIBIT_CYCLES, 1500: system clocks the PS/2 clock is held low before the request-to-send (≥100 us at the target clock).
- TIMEOUT_CYCLES, 200000: maximum system clocks between device falling edges, or waiting for the bus to go idle, before the frame is aborted.
- SYNC_STAGES, 2: synchronizer flops on ps2_clk_in and ps2_data_in.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tx_data  input  8  byte to send.
- tx_valid  input  1  request; accepted when tx_valid && tx_ready.
- tx_ready  output  1  high in IDLE while the synchronized clock and data are both high.
- busy  output  1  high in any state other than IDLE.
- tx_done  output  1  one-cycle pulse: frame sent and ACK received.
- tx_err  output  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  input  1  raw PS/2 clock line.
- ps2_data_in  input  1  raw PS/2 data line.
- ps2_clk_oe  output  1  1 = pull PS/2 clock low.
- ps2_data_oe  output  1  1 = pull PS/2 data low.

Behaviour:
- Reset: state IDLE; ps2_clk_oe, ps2_data_oe, tx_done, tx_err and busy all 0. tx_ready goes 1 once the synchronized lines read high.
- Outputs are registered. Synchronizer output is used everywhere. Falling edge = previous synced clock 1 and current 0.
- IDLE: on accept, latch tx_data and parity = ~^tx_data; next cycle ps2_clk_oe=1 and state INHIBIT. tx_valid without tx_ready is ignored.
- INHIBIT: count INHIBIT_CYCLES. In the last cycle set ps2_data_oe=1 (start bit). Next cycle ps2_clk_oe=0 and state SEND, bit_cnt=0.
- SEND: on each device falling edge, drive the bit at bit_cnt, then increment bit_cnt.
  - bit_cnt 0-7: data bits LSB first.
  - bit_cnt 8: parity.
  - bit_cnt 9: stop (oe=0, line released).
  - After driving stop, go to ACK.
  - Driving bit b means ps2_data_oe = ~b.
- ACK: on the next falling edge, sample data. 0 = ACK → WAIT_IDLE with done flagged; 1 = NACK → WAIT_IDLE with error flagged.
- WAIT_IDLE: wait until synced clock and data are both high, then pulse tx_done or tx_err for one cycle and go to IDLE.
- Timeout: a counter is cleared on each falling edge and on state entry. It runs in SEND, ACK and WAIT_IDLE. Reaching TIMEOUT_CYCLES: both oe=0, tx_err pulse, state IDLE.
- Simultaneous timeout and falling edge in the same cycle: the edge wins and the counter is cleared.
- Reset mid-frame: lines are released the next cycle; no done/err pulse; latched byte discarded.
- bit_cnt is 4-bit and never exceeds 9. The timeout counter saturates rather than wraps.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined: on NACK or timeout, the block re-enters INHIBIT once with the same byte, without pulsing tx_err or lowering busy. tx_err pulses only if the retry also fails; tx_done pulses on retry success.
- Undefined: first failure pulses tx_err immediately, as described in Behaviour.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, SEND, ACK, WAIT_IDLE);
  - constants PS2_DATA_BITS=8, PS2_STOP_IDX=9;
  - odd-parity function.
- Sub-module ps2_sync_edge: SYNC_STAGES synchronizer plus falling-edge detector for clock and data. Shared with the receiver.

Test Plan:
- Device model with ACK. tx_data=0xED, INHIBIT_CYCLES=8 → clock held low 8 cycles. Device samples on its rising edges: start 0; bits 1,0,1,1,0,1,1,1; parity 1; stop 1. Device drives ACK → one tx_done pulse; busy low afterwards.
- tx_data=0xFF → parity bit 1. tx_data=0x00 → parity bit 1. tx_data=0x01 → parity bit 0.
- Device holds data high on the 11th falling edge (NACK) → tx_err pulse, no tx_done, lines released.
- Device stops clocking after 4 bits, TIMEOUT_CYCLES=50 → tx_err at cycle 50 after the last edge; both oe=0.
- reset asserted mid-SEND (bit 5) → next cycle oe=0, busy=0, no pulses. A new tx_valid is accepted once the bus is idle.
- PS2_TX_RETRY_EN defined, first frame NACK, second ACK → two inhibit phases; single tx_done; no tx_err.
